l2_cache_control: RTL and testbench

Control FSM for the 8-way, 8-set, 256-bit-line L2 cache datapath. It accepts one line-sized request at a time from the L1 side, performs tag lookup, and handles hits. On a miss it selects a PLRU victim, writes the victim back if it is dirty, fills the line from physical memory, and then completes the request. It sits between the L1 arbiter and the cacheline adaptor and drives every select and load input of `l2_cache_datapath`.

---
 rtl/l2_cache_control.sv | 174 +++++++++++++++++
 tb/tb_l2_cache_control.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache_control.sv
// Control FSM for the 8-way, 8-set L2 cache datapath: tag lookup, hit
// completion with write merge, PLRU victim writeback and line fill.

package l2_cache_control_pkg;

  typedef enum logic [3:0] {
    cpu,
    dirty_0_write,
    dirty_1_write,
    dirty_2_write,
    dirty_3_write,
    dirty_4_write,
    dirty_5_write,
    dirty_6_write,
    dirty_7_write
  } pmem_addr_mux_sel_t;

  typedef enum logic {
    cacheline_adaptor,
    bus_adaptor
  } data_in_mux_sel_t;

  typedef enum logic [1:0] {
    idle,
    load_mem,
    cpu_write
  } data_write_en_mux_sel_t;

  typedef enum logic [2:0] {
    IDLE,
    TAG,
    COMPARE,
    WRITEBACK,
    FILL
  } state_t;

endpackage

module l2_cache_control
  import l2_cache_control_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  output logic                   mem_resp,
  output logic                   pmem_read,
  output logic                   pmem_write,
  input  logic                   pmem_resp,
  input  logic                   hit,
  input  logic [7:0]             way_hit,
  input  logic [7:0]             valid_out,
  input  logic [7:0]             dirty_out,
  input  logic [2:0]             plru,
  output logic [7:0]             way_load,
  output logic [7:0]             valid_load,
  output logic [7:0]             valid_in,
  output logic [7:0]             dirty_load,
  output logic [7:0]             dirty_in,
  output logic                   lru_load,
  output logic [2:0]             mru,
  output logic [2:0]             way_sel,
  output pmem_addr_mux_sel_t     pmem_address_sel,
  output data_in_mux_sel_t       way_data_in_sel [8],
  output data_write_en_mux_sel_t way_write_en_sel [8],
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
);

  state_t      state;
  logic [2:0]  victim;
  logic [2:0]  hit_way;

  // Lowest set bit of the hit vector picks the hit way (0 when nothing hits)
  always_comb begin
    hit_way = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (way_hit[i]) hit_way = 3'(i);
    end
  end

  // State, victim latch and saturating hit/miss counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      victim     <= 3'd0;
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read | mem_write) state <= TAG;
        end
        TAG: begin
          state <= COMPARE;
        end
        COMPARE: begin
          if (hit) begin
            if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            state <= IDLE;
          end else begin
            victim <= plru;
            if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            if (valid_out[plru] & dirty_out[plru]) state <= WRITEBACK;
            else                                   state <= FILL;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) state <= FILL;
        end
        FILL: begin
          if (pmem_resp) state <= TAG;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Datapath selects and strobes; array writes happen in the same cycle as the
  // hit or memory response that triggers them
  always_comb begin
    mem_resp         = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    way_load         = 8'd0;
    valid_load       = 8'd0;
    valid_in         = 8'd0;
    dirty_load       = 8'd0;
    dirty_in         = 8'd0;
    lru_load         = 1'b0;
    mru              = hit_way;
    way_sel          = hit_way;
    pmem_address_sel = cpu;
    for (int i = 0; i < 8; i++) begin
      way_data_in_sel[i]  = cacheline_adaptor;
      way_write_en_sel[i] = idle;
    end

    case (state)
      COMPARE: begin
        if (hit) begin
          mem_resp = 1'b1;
          lru_load = 1'b1;
          if (mem_write) begin
            way_data_in_sel[hit_way]  = bus_adaptor;
            way_write_en_sel[hit_way] = cpu_write;
            dirty_load[hit_way]       = 1'b1;
            dirty_in[hit_way]         = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        pmem_write       = 1'b1;
        pmem_address_sel = pmem_addr_mux_sel_t'({1'b0, victim} + 4'd1);
        way_sel          = victim;
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          way_write_en_sel[victim] = load_mem;
          way_load[victim]         = 1'b1;
          valid_load[victim]       = 1'b1;
          valid_in[victim]         = 1'b1;
          dirty_load[victim]       = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_l2_cache_control.sv
// Scoreboard bench for l2_cache_control: directed hits, clean and dirty
// misses, resets mid-transaction and counter saturation.

module tb_l2_cache_control;
  import l2_cache_control_pkg::*;

  typedef struct {
    int          cyc;
    logic [2:0]  way;
    bit          wr;
    logic [31:0] hc;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [2:0]  way;
  } fill_t;

  logic                   clk;
  logic                   rst;
  logic                   mem_read;
  logic                   mem_write;
  logic                   mem_resp;
  logic                   pmem_read;
  logic                   pmem_write;
  logic                   pmem_resp;
  logic                   hit;
  logic [7:0]             way_hit;
  logic [7:0]             valid_out;
  logic [7:0]             dirty_out;
  logic [2:0]             plru;
  logic [7:0]             way_load;
  logic [7:0]             valid_load;
  logic [7:0]             valid_in;
  logic [7:0]             dirty_load;
  logic [7:0]             dirty_in;
  logic                   lru_load;
  logic [2:0]             mru;
  logic [2:0]             way_sel;
  pmem_addr_mux_sel_t     pmem_address_sel;
  data_in_mux_sel_t       way_data_in_sel [8];
  data_write_en_mux_sel_t way_write_en_sel [8];
  logic [31:0]            hit_count;
  logic [31:0]            miss_count;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  resp_t resp_q[$];
  fill_t fill_q[$];

  l2_cache_control dut (
    .clk(clk),
    .rst(rst),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_resp(mem_resp),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_resp(pmem_resp),
    .hit(hit),
    .way_hit(way_hit),
    .valid_out(valid_out),
    .dirty_out(dirty_out),
    .plru(plru),
    .way_load(way_load),
    .valid_load(valid_load),
    .valid_in(valid_in),
    .dirty_load(dirty_load),
    .dirty_in(dirty_in),
    .lru_load(lru_load),
    .mru(mru),
    .way_sel(way_sel),
    .pmem_address_sel(pmem_address_sel),
    .way_data_in_sel(way_data_in_sel),
    .way_write_en_sel(way_write_en_sel),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index used to time-stamp expected events
  always @(posedge clk) cyc++;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_defaults(input string tag);
    check_output({tag, "_mem_resp"}, 32'(mem_resp), 32'd0);
    check_output({tag, "_pmem_read"}, 32'(pmem_read), 32'd0);
    check_output({tag, "_pmem_write"}, 32'(pmem_write), 32'd0);
    check_output({tag, "_strobes"}, {way_load, valid_load, dirty_load, valid_in}, 32'd0);
    check_output({tag, "_dirty_in_lru"}, {23'd0, dirty_in, lru_load}, 32'd0);
    check_output({tag, "_addr_sel"}, 32'(pmem_address_sel), 32'(cpu));
    for (int i = 0; i < 8; i++) begin
      check_output({tag, "_data_in_sel"}, 32'(way_data_in_sel[i]), 32'(cacheline_adaptor));
      check_output({tag, "_write_en_sel"}, 32'(way_write_en_sel[i]), 32'(idle));
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes or fills
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_resp) begin
        if (resp_q.size() == 0) begin
          check_output("unexpected_mem_resp", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          check_output("resp_cycle", 32'(cyc), 32'(r.cyc));
          check_output("resp_way_sel", 32'(way_sel), 32'(r.way));
          check_output("resp_mru", 32'(mru), 32'(r.way));
          check_output("resp_lru_load", 32'(lru_load), 32'd1);
          check_output("resp_hit_count", hit_count, r.hc);
          check_output("resp_dirty_load", 32'(dirty_load), r.wr ? 32'(8'h01 << r.way) : 32'd0);
          check_output("resp_dirty_in", 32'(dirty_in), r.wr ? 32'(8'h01 << r.way) : 32'd0);
          check_output("resp_write_en_sel", 32'(way_write_en_sel[r.way]),
                       r.wr ? 32'(cpu_write) : 32'(idle));
          check_output("resp_data_in_sel", 32'(way_data_in_sel[r.way]),
                       r.wr ? 32'(bus_adaptor) : 32'(cacheline_adaptor));
        end
      end
      if (way_load != 8'd0) begin
        if (fill_q.size() == 0) begin
          check_output("unexpected_fill", 32'(way_load), 32'd0);
        end else begin
          fill_t f;
          f = fill_q.pop_front();
          check_output("fill_cycle", 32'(cyc), 32'(f.cyc));
          check_output("fill_way_load", 32'(way_load), 32'(8'h01 << f.way));
          check_output("fill_valid_load", 32'(valid_load), 32'(8'h01 << f.way));
          check_output("fill_valid_in", 32'(valid_in), 32'(8'h01 << f.way));
          check_output("fill_dirty_load", 32'(dirty_load), 32'(8'h01 << f.way));
          check_output("fill_dirty_in", 32'(dirty_in), 32'd0);
          check_output("fill_write_en_sel", 32'(way_write_en_sel[f.way]), 32'(load_mem));
        end
      end
      if (pmem_read && pmem_write) begin
        check_output("pmem_read_write_both", 32'd1, 32'd0);
      end
    end
  end

  // Hit request: datapath reports a hit on the given way vector in TAG/COMPARE
  task automatic apply_hit(input bit rd, input bit wr, input logic [7:0] hv,
                           input logic [2:0] exp_way, input logic [31:0] exp_hc);
    resp_t r;
    r.cyc = cyc + 2;
    r.way = exp_way;
    r.wr  = wr;
    r.hc  = exp_hc;
    resp_q.push_back(r);
    mem_read  = rd;
    mem_write = wr;
    next_cycle();
    hit     = 1'b1;
    way_hit = hv;
    next_cycle();
    next_cycle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    hit       = 1'b0;
    way_hit   = 8'd0;
  endtask

  // Miss request: optional writeback, fill, then re-lookup hit on the victim
  task automatic apply_miss(input bit rd, input bit wr, input logic [2:0] p, input bit dirty,
                            input pmem_addr_mux_sel_t exp_wb_sel, input int wb_lat,
                            input int fill_lat, input logic [31:0] exp_hc,
                            input logic [31:0] exp_mc);
    int c0;
    int f;
    resp_t r;
    fill_t fl;
    c0 = cyc;
    f  = dirty ? c0 + 4 + wb_lat : c0 + 3;
    fl.cyc = f + fill_lat;
    fl.way = p;
    fill_q.push_back(fl);
    r.cyc = f + fill_lat + 2;
    r.way = p;
    r.wr  = wr;
    r.hc  = exp_hc;
    resp_q.push_back(r);
    mem_read  = rd;
    mem_write = wr;
    hit       = 1'b0;
    way_hit   = 8'd0;
    plru      = p;
    next_cycle();
    next_cycle();
    if (dirty) begin
      valid_out = 8'h01 << p;
      dirty_out = 8'h01 << p;
    end
    @(negedge clk);
    check_output("compare_no_pmem", {30'd0, pmem_read, pmem_write}, 32'd0);
    next_cycle();
    valid_out = 8'd0;
    dirty_out = 8'd0;
    plru      = 3'd0;
    if (dirty) begin
      for (int k = 0; k <= wb_lat; k++) begin
        pmem_resp = (k == wb_lat);
        @(negedge clk);
        check_output("wb_pmem_write", 32'(pmem_write), 32'd1);
        check_output("wb_pmem_read", 32'(pmem_read), 32'd0);
        check_output("wb_addr_sel", 32'(pmem_address_sel), 32'(exp_wb_sel));
        check_output("wb_way_sel", 32'(way_sel), 32'(p));
        next_cycle();
      end
      pmem_resp = 1'b0;
    end
    for (int k = 0; k <= fill_lat; k++) begin
      pmem_resp = (k == fill_lat);
      @(negedge clk);
      check_output("fill_pmem_read", 32'(pmem_read), 32'd1);
      check_output("fill_pmem_write", 32'(pmem_write), 32'd0);
      check_output("fill_addr_sel", 32'(pmem_address_sel), 32'(cpu));
      next_cycle();
    end
    pmem_resp = 1'b0;
    hit       = 1'b1;
    way_hit   = 8'h01 << p;
    @(negedge clk);
    check_output("tag_pmem_read_dropped", 32'(pmem_read), 32'd0);
    next_cycle();
    next_cycle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    hit       = 1'b0;
    way_hit   = 8'd0;
    check_output("miss_count", miss_count, exp_mc);
  endtask

  initial begin
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
    hit       = 1'b0;
    way_hit   = 8'd0;
    valid_out = 8'd0;
    dirty_out = 8'd0;
    plru      = 3'd0;
    #3;
    check_defaults("reset");
    check_output("reset_way_sel", 32'(way_sel), 32'd0);
    check_output("reset_hit_count", hit_count, 32'd0);
    check_output("reset_miss_count", miss_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();

    // Clean read miss, victim way 3, memory answers 4 cycles into FILL
    apply_miss(1'b1, 1'b0, 3'd3, 1'b0, cpu, 0, 4, 32'd0, 32'd1);
    check_output("after_miss_hit_count", hit_count, 32'd1);

    // Write hit in way 5
    apply_hit(1'b0, 1'b1, 8'h20, 3'd5, 32'd1);
    // Read hit with two ways flagged: lowest wins
    apply_hit(1'b1, 1'b0, 8'h81, 3'd0, 32'd2);

    // Dirty write miss: evict way 6, then fill and merge the write
    apply_miss(1'b0, 1'b1, 3'd6, 1'b1, dirty_6_write, 2, 3, 32'd3, 32'd2);
    check_output("after_dirty_hit_count", hit_count, 32'd4);

    // Read and write together behave as a write
    apply_hit(1'b1, 1'b1, 8'h80, 3'd7, 32'd4);

    // Reset two cycles into FILL abandons the fill
    mem_read = 1'b1;
    plru     = 3'd2;
    next_cycle();
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_output("prereset_pmem_read", 32'(pmem_read), 32'd1);
    check_output("prereset_miss_count", miss_count, 32'd3);
    next_cycle();
    #2;
    rst = 1'b1;
    #1;
    check_defaults("midfill");
    check_output("midfill_hit_count", hit_count, 32'd0);
    check_output("midfill_miss_count", miss_count, 32'd0);
    check_output("midfill_state", 32'(dut.state), 32'(IDLE));
    mem_read  = 1'b0;
    plru      = 3'd0;
    pmem_resp = 1'b1;
    #1;
    check_output("midfill_resp_no_load", 32'(way_load), 32'd0);
    @(negedge clk);
    pmem_resp = 1'b0;
    rst       = 1'b0;
    next_cycle();
    check_output("postreset_state", 32'(dut.state), 32'(IDLE));

    // Re-issued request misses again
    apply_miss(1'b1, 1'b0, 3'd2, 1'b0, cpu, 0, 1, 32'd0, 32'd1);

    // Stray memory response while idle
    pmem_resp = 1'b1;
    @(negedge clk);
    check_output("spurious_pmem_read", 32'(pmem_read), 32'd0);
    check_output("spurious_way_load", 32'(way_load), 32'd0);
    next_cycle();
    pmem_resp = 1'b0;
    @(negedge clk);
    check_output("spurious_state", 32'(dut.state), 32'(IDLE));
    next_cycle();

    // Saturation: preload the hit counter at its ceiling
    @(negedge clk);
    force dut.hit_count = 32'hFFFF_FFFF;
    next_cycle();
    release dut.hit_count;
    apply_hit(1'b1, 1'b0, 8'h02, 3'd1, 32'hFFFF_FFFF);
    check_output("saturated_hit_count", hit_count, 32'hFFFF_FFFF);
    check_output("final_miss_count", miss_count, 32'd1);

    next_cycle();
    next_cycle();
    check_output("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    check_output("fill_queue_drained", 32'(fill_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
